button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable samples required to accept a level change (range 1..2^24-1).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, cycles in HELD before the first repeat pulse (range 1..2^28-1).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between subsequent repeat pulses (range 1..2^28-1).
REQ-004 The block SHALL have parameter REPEAT_EN, default 1; 0 = repeat_p never asserts.
REQ-005 The block SHALL have parameter ACTIVE_LOW, default 0; 1 = btn_raw is pressed when 0.
REQ-006 The block SHALL have port clk, input, 1 bit, single system clock (100 MHz board clock), all logic on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, reset; asynchronous assert, active-low.
REQ-008 The block SHALL have port btn_raw, input, 1 bit, asynchronous raw button pin.
REQ-009 The block SHALL have port pressed, output, 1 bit, debounced level, 1 = button held.
REQ-010 The block SHALL have port press_p, output, 1 bit, one-cycle pulse on accepted press.
REQ-011 The block SHALL have port release_p, output, 1 bit, one-cycle pulse on accepted release.
REQ-012 The block SHALL have port repeat_p, output, 1 bit, one-cycle auto-repeat pulse while held.

Function
REQ-013 The block SHALL pass btn_raw through a 2-flop synchroniser, polarity-normalised so that sync = 1 means pressed; no other logic shall sample btn_raw.
REQ-014 The block SHALL implement FSM states IDLE, PRESS_WAIT, HELD, REL_WAIT, using a debounce counter (24 bit) and a repeat counter (28 bit).
REQ-015 In IDLE, sync = 1 SHALL move the FSM to PRESS_WAIT with the debounce count set to 1.
REQ-016 In PRESS_WAIT, sync = 0 SHALL return the FSM to IDLE and clear the count, with no output change (bounce rejected).
REQ-017 In PRESS_WAIT, sync = 1 SHALL increment the count; on the sample that makes the count equal DEBOUNCE_CYCLES, the FSM SHALL go to HELD and register press_p = 1 (one cycle) and pressed = 1.
REQ-018 With DEBOUNCE_CYCLES = 1, the FSM SHALL go from IDLE directly to HELD on the first sync = 1 sample.
REQ-019 Latency SHALL be defined with edge 0 as the first edge capturing btn_raw active: press_p is high in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-020 In HELD, sync = 0 SHALL move the FSM to REL_WAIT with the count set to 1; pressed stays 1.
REQ-021 In REL_WAIT, sync = 1 SHALL return the FSM to HELD with no press_p (glitch rejected).
REQ-022 In REL_WAIT, reaching DEBOUNCE_CYCLES consecutive sync = 0 samples SHALL move the FSM to IDLE and register release_p = 1 (one cycle) and pressed = 0 in the same cycle.
REQ-023 The repeat counter SHALL clear on entry to HELD from PRESS_WAIT and increment each cycle in HELD.
REQ-024 The repeat counter SHALL freeze in REL_WAIT and resume on return to HELD.
REQ-025 The repeat counter SHALL clear in IDLE.
REQ-026 With REPEAT_EN = 1, repeat_p SHALL pulse when the repeat count reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that while in HELD.
REQ-027 The repeat count SHALL reload so that it never wraps.
REQ-028 press_p, release_p and repeat_p SHALL be mutually exclusive in any cycle; repeat_p SHALL assert only in HELD.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from btn_raw to any output.
REQ-030 Counters SHALL saturate at DEBOUNCE_CYCLES and SHALL never exceed their width.

Reset
REQ-031 While rst_n = 0, the block SHALL hold the FSM in IDLE, both counters at 0, both synchroniser flops at the not-pressed level, and pressed, press_p, release_p and repeat_p all at 0, regardless of clk.
REQ-032 Reset deassertion SHALL take effect at the first clk edge with rst_n = 1.
REQ-033 A button held through reset SHALL produce press_p with normal latency after deassertion.
REQ-034 Reset asserted mid-debounce or in HELD SHALL produce no release_p.

Verification
REQ-035 The bench SHALL run all scenarios with DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, ACTIVE_LOW = 0 unless stated.
REQ-036 Clean press: btn_raw 0->1 before edge 0 and held -> press_p = 1 only in the cycle after edge 6; pressed = 1 from then on; no other pulses.
REQ-037 Bounce: btn_raw high for 3 edges then low -> press_p, pressed and repeat_p stay 0; FSM back in IDLE.
REQ-038 Release glitch: in HELD, btn_raw low for 2 cycles then high -> release_p = 0, pressed stays 1, repeat schedule delayed by exactly the frozen cycles.
REQ-039 Auto-repeat: hold 25 cycles after press_p -> repeat_p at 10, 13, 16, 19, 22 cycles after press_p; then btn_raw low -> release_p 6 edges later, pressed = 0, no further repeat_p.
REQ-040 Reset: btn_raw held 1 with rst_n = 0 -> all outputs 0; rst_n 0->1 -> press_p 6 edges after deassertion; then rst_n pulsed low while in HELD -> pressed = 0 immediately, no release_p.
REQ-041 Polarity: ACTIVE_LOW = 1, REPEAT_EN = 0, btn_raw 1->0 held 40 cycles -> press_p once, no repeat_p.

Source files
------------

// File: rtl/button_debounce.sv
// Debounced push-button: synchroniser, press/release debounce FSM and auto-repeat.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pressed,
  output logic press_p,
  output logic release_p,
  output logic repeat_p
);

  localparam int unsigned DbW = 24;
  localparam int unsigned RepW = 28;
  localparam logic [DbW-1:0]  DbTarget  = DbW'(DEBOUNCE_CYCLES);
  localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepPeriod = RepW'(REPEAT_PERIOD);
  localparam logic            IdleLevel = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_e;

  logic            meta_q;
  logic            sync_raw_q;
  logic            sync_q;
  state_e          state_q;
  logic [DbW-1:0]  db_cnt_q;
  logic [DbW-1:0]  db_cnt_d;
  logic [RepW-1:0] rep_cnt_q;
  logic [RepW-1:0] rep_cnt_d;
  logic [RepW-1:0] rep_target;
  logic            rep_after_first_q;
  logic            db_hit;
  logic            rep_hit;
  logic            pressed_q;
  logic            press_p_q;
  logic            release_p_q;
  logic            repeat_p_q;

  // Two-flop synchroniser on the raw pin, then a normalised sample (1 = pressed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= IdleLevel;
      sync_raw_q <= IdleLevel;
      sync_q     <= 1'b0;
    end else begin
      meta_q     <= btn_raw;
      sync_raw_q <= meta_q;
      sync_q     <= sync_raw_q ^ IdleLevel;
    end
  end

  // Counter increments and terminal-count detection; debounce count is 0 in IDLE/HELD.
  always_comb begin
    db_cnt_d   = db_cnt_q + DbW'(1);
    rep_cnt_d  = rep_cnt_q + RepW'(1);
    rep_target = rep_after_first_q ? RepPeriod : RepDelay;
    db_hit     = (db_cnt_d == DbTarget);
    rep_hit    = (rep_cnt_d == rep_target);
  end

  // Debounce FSM with repeat scheduling and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      db_cnt_q          <= '0;
      rep_cnt_q         <= '0;
      rep_after_first_q <= 1'b0;
      pressed_q         <= 1'b0;
      press_p_q         <= 1'b0;
      release_p_q       <= 1'b0;
      repeat_p_q        <= 1'b0;
    end else begin
      press_p_q   <= 1'b0;
      release_p_q <= 1'b0;
      repeat_p_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          rep_cnt_q         <= '0;
          rep_after_first_q <= 1'b0;
          if (sync_q) begin
            if (db_hit) begin
              state_q   <= HELD;
              db_cnt_q  <= '0;
              pressed_q <= 1'b1;
              press_p_q <= 1'b1;
            end else begin
              state_q  <= PRESS_WAIT;
              db_cnt_q <= db_cnt_d;
            end
          end
        end
        PRESS_WAIT: begin
          if (!sync_q) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else if (db_hit) begin
            state_q           <= HELD;
            db_cnt_q          <= '0;
            rep_cnt_q         <= '0;
            rep_after_first_q <= 1'b0;
            pressed_q         <= 1'b1;
            press_p_q         <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_d;
          end
        end
        HELD: begin
          if (!sync_q) begin
            if (db_hit) begin
              state_q           <= IDLE;
              db_cnt_q          <= '0;
              rep_cnt_q         <= '0;
              rep_after_first_q <= 1'b0;
              pressed_q         <= 1'b0;
              release_p_q       <= 1'b1;
            end else begin
              state_q  <= REL_WAIT;
              db_cnt_q <= db_cnt_d;
            end
          end else if (rep_hit) begin
            // Reload instead of letting the count run on, so it can never wrap.
            rep_cnt_q         <= '0;
            rep_after_first_q <= 1'b1;
            repeat_p_q        <= REPEAT_EN;
          end else begin
            rep_cnt_q <= rep_cnt_d;
          end
        end
        REL_WAIT: begin
          if (sync_q) begin
            state_q  <= HELD;
            db_cnt_q <= '0;
          end else if (db_hit) begin
            state_q           <= IDLE;
            db_cnt_q          <= '0;
            rep_cnt_q         <= '0;
            rep_after_first_q <= 1'b0;
            pressed_q         <= 1'b0;
            release_p_q       <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          db_cnt_q <= '0;
        end
      endcase
    end
  end

  assign pressed   = pressed_q;
  assign press_p   = press_p_q;
  assign release_p = release_p_q;
  assign repeat_p  = repeat_p_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce against a sample-history reference model.
module tb_button_debounce;

  localparam int unsigned DC = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic btn_al = 1'b1;
  logic pressed, press_p, release_p, repeat_p;
  logic pressed_al, press_p_al, release_p_al, repeat_p_al;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model state: debounced level, run of samples disagreeing with it,
  // and number of cycles spent held-and-stable since the accepted press.
  logic m_level, m_press, m_rel, m_rep;
  int   opp_run;
  int   held;
  logic dly_q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn),
    .pressed(pressed), .press_p(press_p), .release_p(release_p), .repeat_p(repeat_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_al),
    .pressed(pressed_al), .press_p(press_p_al), .release_p(release_p_al), .repeat_p(repeat_p_al)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    dly_q = {};
    for (int i = 0; i < 3; i++) dly_q.push_back(1'b0);
    m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
    opp_run = 0; held = 0;
  endtask

  // A raw sample reaches the decision logic three edges after it is captured.
  task automatic model_edge(input logic raw);
    logic seen;
    seen = dly_q.pop_front();
    dly_q.push_back(raw);
    m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
    if (seen != m_level) begin
      opp_run++;
      if (opp_run == int'(DC)) begin
        m_level = ~m_level;
        opp_run = 0;
        if (m_level) begin
          m_press = 1'b1;
          held = 0;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      if (m_level && opp_run == 0) begin
        held++;
        if (held >= int'(RD) && ((held - int'(RD)) % int'(RP)) == 0) m_rep = 1'b1;
      end
      opp_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(btn);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    int rel_seen;
    rst_n = 1'b0; btn = 1'b1; btn_al = 1'b1;
    model_reset();
    repeat (4) tick();
    n_checks++;
    if ({pressed, press_p, release_p, repeat_p} !== 4'b0000)
      $display("FAIL reset_hold outputs=%b expected=0000", {pressed, press_p, release_p, repeat_p});
    else n_pass++;
    n_checks++;
    if ({pressed_al, press_p_al, release_p_al, repeat_p_al} !== 4'b0000)
      $display("FAIL reset_hold_al outputs=%b expected=0000", {pressed_al, press_p_al, release_p_al, repeat_p_al});
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      n_checks++;
      if (press_p !== 1'(i == 6))
        $display("FAIL reset_press_latency edge=%0d press_p=%b expected=%b", i, press_p, 1'(i == 6));
      else n_pass++;
    end
    repeat (3) begin
      tick();
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== {m_level, m_press, m_rel, m_rep})
        $display("FAIL reset_held cyc=%0d got=%b exp=%b", cyc, {pressed, press_p, release_p, repeat_p}, {m_level, m_press, m_rel, m_rep});
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pressed, press_p, release_p, repeat_p} !== 4'b0000)
      $display("FAIL reset_in_held outputs=%b expected=0000", {pressed, press_p, release_p, repeat_p});
    else n_pass++;
    model_reset();
    rel_seen = 0;
    repeat (3) begin
      tick();
      if (release_p) rel_seen++;
    end
    btn = 1'b0;
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      if (release_p) rel_seen++;
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== {m_level, m_press, m_rel, m_rep})
        $display("FAIL reset_recover cyc=%0d got=%b exp=%b", cyc, {pressed, press_p, release_p, repeat_p}, {m_level, m_press, m_rel, m_rep});
      else n_pass++;
    end
    n_checks++;
    if (rel_seen != 0) $display("FAIL reset_no_release release_pulses=%0d expected=0", rel_seen);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    btn = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== {1'(i == 6), 1'(i == 6), 1'b0, 1'b0})
        $display("FAIL clean_press edge=%0d got=%b exp=%b", i, {pressed, press_p, release_p, repeat_p}, {1'(i == 6), 1'(i == 6), 2'b00});
      else n_pass++;
    end
    btn = 1'b0;
    repeat (12) begin
      tick();
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== {m_level, m_press, m_rel, m_rep})
        $display("FAIL clean_release cyc=%0d got=%b exp=%b", cyc, {pressed, press_p, release_p, repeat_p}, {m_level, m_press, m_rel, m_rep});
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    btn = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if ({pressed, press_p, repeat_p} !== 3'b000)
        $display("FAIL bounce_high cyc=%0d got=%b exp=000", cyc, {pressed, press_p, repeat_p});
      else n_pass++;
    end
    btn = 1'b0;
    repeat (8) begin
      tick();
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== 4'b0000)
        $display("FAIL bounce_low cyc=%0d got=%b exp=0000", cyc, {pressed, press_p, release_p, repeat_p});
      else n_pass++;
    end
  endtask

  task automatic test_release_glitch();
    int p_cyc;
    int first_rep;
    int bad;
    p_cyc = -1; first_rep = -1; bad = 0;
    btn = 1'b1;
    for (int i = 0; i < 20 && p_cyc < 0; i++) begin
      tick();
      if (press_p) p_cyc = cyc;
    end
    n_checks++;
    if (p_cyc < 0) $display("FAIL glitch_press_timeout press_p=%b expected=1", press_p);
    else n_pass++;
    tick();
    btn = 1'b0;
    tick();
    tick();
    btn = 1'b1;
    repeat (20) begin
      tick();
      if (release_p !== 1'b0 || pressed !== 1'b1) bad++;
      if (repeat_p && first_rep < 0) first_rep = cyc - p_cyc;
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== {m_level, m_press, m_rel, m_rep})
        $display("FAIL glitch_model cyc=%0d got=%b exp=%b", cyc, {pressed, press_p, release_p, repeat_p}, {m_level, m_press, m_rel, m_rep});
      else n_pass++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL glitch_held bad_cycles=%0d expected=0", bad);
    else n_pass++;
    // Two low samples plus the edge returning to HELD do not advance the repeat count.
    n_checks++;
    if (first_rep != int'(RD) + 3) $display("FAIL glitch_repeat_delay first_repeat=%0d expected=%0d", first_rep, int'(RD) + 3);
    else n_pass++;
    btn = 1'b0;
    repeat (12) begin
      tick();
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== {m_level, m_press, m_rel, m_rep})
        $display("FAIL glitch_release cyc=%0d got=%b exp=%b", cyc, {pressed, press_p, release_p, repeat_p}, {m_level, m_press, m_rel, m_rep});
      else n_pass++;
    end
  endtask

  task automatic test_auto_repeat();
    int p_cyc;
    int rel_off;
    int reps[$];
    int exp_reps[5];
    exp_reps = '{10, 13, 16, 19, 22};
    p_cyc = -1; rel_off = -1;
    btn = 1'b1;
    for (int i = 0; i < 20 && p_cyc < 0; i++) begin
      tick();
      if (press_p) p_cyc = cyc;
    end
    n_checks++;
    if (p_cyc < 0) $display("FAIL repeat_press_timeout press_p=%b expected=1", press_p);
    else n_pass++;
    for (int off = 1; off <= 35; off++) begin
      tick();
      if (repeat_p) reps.push_back(off);
      if (release_p) rel_off = off;
      n_checks++;
      if ({pressed, press_p, release_p, repeat_p} !== {m_level, m_press, m_rel, m_rep})
        $display("FAIL repeat_model off=%0d got=%b exp=%b", off, {pressed, press_p, release_p, repeat_p}, {m_level, m_press, m_rel, m_rep});
      else n_pass++;
      if (off == 21) btn = 1'b0;
    end
    n_checks++;
    if (reps.size() != 5) $display("FAIL repeat_count pulses=%0d expected=5", reps.size());
    else n_pass++;
    for (int k = 0; k < 5 && k < reps.size(); k++) begin
      n_checks++;
      if (reps[k] != exp_reps[k]) $display("FAIL repeat_offset idx=%0d offset=%0d expected=%0d", k, reps[k], exp_reps[k]);
      else n_pass++;
    end
    n_checks++;
    if (rel_off != 28) $display("FAIL repeat_release_offset offset=%0d expected=28", rel_off);
    else n_pass++;
    n_checks++;
    if (pressed !== 1'b0) $display("FAIL repeat_pressed_end pressed=%b expected=0", pressed);
    else n_pass++;
  endtask

  task automatic test_polarity();
    int presses;
    int repeats;
    int releases;
    presses = 0; repeats = 0; releases = 0;
    btn_al = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (press_p_al) presses++;
      if (repeat_p_al) repeats++;
      if (release_p_al) releases++;
      if (i == 6) begin
        n_checks++;
        if (press_p_al !== 1'b1) $display("FAIL polarity_latency press_p=%b expected=1", press_p_al);
        else n_pass++;
      end
    end
    n_checks++;
    if (presses != 1 || repeats != 0 || releases != 0)
      $display("FAIL polarity_pulses press=%0d repeat=%0d release=%0d expected=1/0/0", presses, repeats, releases);
    else n_pass++;
    n_checks++;
    if (pressed_al !== 1'b1) $display("FAIL polarity_pressed pressed=%b expected=1", pressed_al);
    else n_pass++;
    btn_al = 1'b1;
    repeat (10) begin
      tick();
      if (release_p_al) releases++;
    end
    n_checks++;
    if (releases != 1 || pressed_al !== 1'b0)
      $display("FAIL polarity_release releases=%0d pressed=%b expected=1/0", releases, pressed_al);
    else n_pass++;
  endtask

  task automatic test_random();
    int run;
    for (int r = 0; r < 80; r++) begin
      btn = 1'($urandom_range(0, 1));
      run = $urandom_range(1, 24);
      for (int i = 0; i < run; i++) begin
        tick();
        n_checks++;
        if ({pressed, press_p, release_p, repeat_p} !== {m_level, m_press, m_rel, m_rep})
          $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {pressed, press_p, release_p, repeat_p}, {m_level, m_press, m_rel, m_rep});
        else n_pass++;
        n_checks++;
        if ($countones({press_p, release_p, repeat_p}) > 1 || (repeat_p && !pressed))
          $display("FAIL random_exclusive cyc=%0d pulses=%b pressed=%b expected=onehot0", cyc, {press_p, release_p, repeat_p}, pressed);
        else n_pass++;
      end
    end
    btn = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_clean_press();
    test_release_glitch();
    test_auto_repeat();
    test_polarity();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
